maze_mem: RTL

MAZE_MEM -- requirements
Module: maze_mem

---
 rtl/maze_if.sv | 33 +++
 rtl/maze_mem.sv | 128 ++++++++++++
 2 files changed

// File: rtl/maze_if.sv
// maze_if -- solver and loader signal bundle for maze_mem.
//
// Solver side : row/col cell address, maze_oe read request, maze_we visit mark,
//               maze_in registered wall bit back to the solver.
// Loader side : load_data/load_valid/load_ready byte stream, start_load pulse.
// Status      : loaded, visit_count, access_err.
//
// The master modport is the solver/loader side, and the slave modport is the
// maze memory.
interface maze_if;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        maze_oe;
    logic        maze_we;
    logic        maze_in;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_ready;
    logic        start_load;
    logic        loaded;
    logic [12:0] visit_count;
    logic        access_err;

    modport master (
        output row, col, maze_oe, maze_we, load_data, load_valid, start_load,
        input  maze_in, load_ready, loaded, visit_count, access_err
    );

    modport slave (
        input  row, col, maze_oe, maze_we, load_data, load_valid, start_load,
        output maze_in, load_ready, loaded, visit_count, access_err
    );
endinterface

// File: rtl/maze_mem.sv
// maze_mem -- 64x64 maze wall store plus a 64x64 visited map for a maze solver.
//
// Ports
//   clk  : single clock, all state changes on the rising edge.
//   rst  : synchronous active-high reset.
//   bus  : maze_if.slave. It carries the solver read/mark port, the byte-wide
//          image load stream and the status outputs.
//
// Operation
//   CLEAR : wipes one visited row per cycle (rows 0..63), then enters LOAD.
//   LOAD  : accepts 512 image bytes. Byte k fills row k>>3, columns
//           (k&7)*8 .. (k&7)*8+7, with the LSB at the lowest column.
//   SERVE : answers wall reads with a 1-cycle latency and records visit marks.
//           start_load returns the FSM to CLEAR.
module maze_mem (
    input  logic   clk,
    input  logic   rst,
    maze_if.slave  bus
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  clr_row_q;     // visited row being wiped in CLEAR
    logic [8:0]  byte_cnt_q;    // load transfer index k, 0..511
    logic [55:0] row_buf_q;     // first seven bytes of the row being loaded
    logic        maze_in_q;
    logic [12:0] visit_count_q;
    logic        access_err_q;

    logic [63:0] wall_mem [64];
    logic [63:0] vis_mem  [64];

    logic in_serve;
    logic xfer;
    logic restart;
    logic rd_ok;
    logic wr_ok;
    logic vis_bit;

    assign in_serve = (state_q == SERVE);
    assign xfer     = (state_q == LOAD) && bus.load_valid;
    assign restart  = in_serve && bus.start_load;
    assign rd_ok    = in_serve && bus.maze_oe;
    // A mark that coincides with start_load is dropped. The visited map is
    // about to be wiped, so the mark could not survive anyway.
    assign wr_ok    = in_serve && bus.maze_we && !bus.start_load;
    assign vis_bit  = vis_mem[bus.row][bus.col];

    assign bus.load_ready  = (state_q == LOAD);
    assign bus.loaded      = in_serve;
    assign bus.maze_in     = maze_in_q;
    assign bus.visit_count = visit_count_q;
    assign bus.access_err  = access_err_q;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR:   if (clr_row_q == 6'd63)            state_d = LOAD;
            LOAD:    if (xfer && byte_cnt_q == 9'd511)  state_d = SERVE;
            SERVE:   if (bus.start_load)                state_d = CLEAR;
            default:                                    state_d = CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CLEAR;
            clr_row_q     <= '0;
            byte_cnt_q    <= '0;
            maze_in_q     <= 1'b0;
            visit_count_q <= '0;
            access_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            // The counter wraps 63 -> 0 on leaving CLEAR, so the next clear
            // starts at row 0 again.
            if (state_q == CLEAR)
                clr_row_q <= clr_row_q + 6'd1;

            // The counter wraps 511 -> 0 on the final transfer.
            if (xfer)
                byte_cnt_q <= byte_cnt_q + 9'd1;

            if (rd_ok)
                maze_in_q <= wall_mem[bus.row][bus.col];

            if (restart) begin
                visit_count_q <= '0;
                access_err_q  <= 1'b0;
            end else begin
                if (wr_ok && !vis_bit)
                    visit_count_q <= visit_count_q + 13'd1;
                if (!in_serve && (bus.maze_oe || bus.maze_we))
                    access_err_q <= 1'b1;
            end
        end
    end

    // NOTE: the arrays are not reset, because a reset cannot clear 64 rows in
    // one cycle. Visited rows are wiped by the CLEAR walk, and wall rows are
    // overwritten by each load. The row buffer needs no reset either, because
    // each row is rebuilt from byte 0 before it is written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR)
                vis_mem[clr_row_q] <= '0;
            if (wr_ok)
                vis_mem[bus.row][bus.col] <= 1'b1;

            if (xfer) begin
                if (byte_cnt_q[2:0] == 3'd7)
                    wall_mem[byte_cnt_q[8:3]] <= {bus.load_data, row_buf_q};
                else
                    row_buf_q[{byte_cnt_q[2:0], 3'b000} +: 8] <= bus.load_data;
            end
        end
    end

endmodule
